// File: rtl/io_replay.sv
// io_replay: replays saved paging/border state into the port decoder
// as Z80-style I/O write cycles on the CPU-side bus.
module io_replay #(
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 2
) (
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  en,
    input  logic [7:0]  val_fe,
    input  logic [7:0]  val_7ffd,
    input  logic [7:0]  val_dffd,
    input  logic [7:0]  val_1ffd,
    input  logic        bus_grant,
    output logic        bus_req,
    output logic        bus_own,
    output logic [15:0] io_a,
    output logic [7:0]  io_d,
    output logic        io_ioreq,
    output logic        io_wr,
    output logic        busy,
    output logic        done
);

    localparam int TM1  = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
    localparam int TMAX = (TM1 > T_HOLD) ? TM1 : T_HOLD;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] LD_SETUP  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_STROBE = CW'(T_STROBE - 1);
    localparam logic [CW-1:0] LD_HOLD   = CW'(T_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    en_q, en_d;
    logic [7:0]    fe_q, fe_d;
    logic [7:0]    p7_q, p7_d;
    logic [7:0]    pd_q, pd_d;
    logic [7:0]    p1_q, p1_d;

    logic          req_q, req_d;
    logic          own_q, own_d;
    logic [15:0]   a_q, a_d;
    logic [7:0]    dat_q, dat_d;
    logic          stb_q, stb_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [3:0]    first_hit;
    logic [3:0]    next_hit;
    logic [23:0]   ent;

    // Entry 0 and 2 both target DFFD, so en[2] gates two list slots.
    function automatic logic [3:0] find(
        input logic [3:0] e,
        input logic [2:0] from
    );
        logic [4:0] m;
        m = {e[0], e[3], e[2], e[1], e[2]};
        find = 4'b0000;
        for (int i = 4; i >= 0; i--) begin
            if (i >= int'(from) && m[i]) begin
                find = {1'b1, 3'(i)};
            end
        end
    endfunction

    function automatic logic [23:0] entry(
        input logic [2:0] i,
        input logic [7:0] fe,
        input logic [7:0] p7,
        input logic [7:0] pd,
        input logic [7:0] p1
    );
        unique case (i)
            3'd0:    entry = {16'hDFFD, pd | 8'h10};
            3'd1:    entry = {16'h7FFD, p7};
            3'd2:    entry = {16'hDFFD, pd};
            3'd3:    entry = {16'h1FFD, p1};
            3'd4:    entry = {16'h00FE, fe};
            default: entry = 24'h0;
        endcase
    endfunction

    assign first_hit = find(en, 3'd0);
    assign next_hit  = find(en_q, idx_q + 3'd1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        fe_d    = fe_q;
        p7_d    = p7_q;
        pd_d    = pd_q;
        p1_d    = p1_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (!first_hit[3]) begin
                        state_d = DONE;
                    end else begin
                        en_d    = en;
                        fe_d    = val_fe;
                        p7_d    = val_7ffd;
                        pd_d    = val_dffd;
                        p1_d    = val_1ffd;
                        idx_d   = first_hit[2:0];
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_grant) begin
                    state_d = SETUP;
                    cnt_d   = LD_SETUP;
                end
            end
            SETUP: begin
                if (!bus_grant) begin
                    state_d = REQ;
                end else if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = LD_STROBE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            // Grant is deliberately not looked at: a strobe always runs out.
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (next_hit[3]) begin
                    idx_d = next_hit[2:0];
                    if (bus_grant) begin
                        state_d = SETUP;
                        cnt_d   = LD_SETUP;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so they come out registered.
    always_comb begin
        own_d  = (state_d == SETUP) || (state_d == STROBE)
              || (state_d == HOLD);
        req_d  = own_d || (state_d == REQ);
        stb_d  = (state_d == STROBE);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        ent    = entry(idx_d, fe_d, p7_d, pd_d, p1_d);
        a_d    = 16'h0000;
        dat_d  = 8'h00;
        if (own_d) begin
            a_d   = ent[23:8];
            dat_d = ent[7:0];
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            en_q    <= 4'h0;
            fe_q    <= 8'h00;
            p7_q    <= 8'h00;
            pd_q    <= 8'h00;
            p1_q    <= 8'h00;
            req_q   <= 1'b0;
            own_q   <= 1'b0;
            a_q     <= 16'h0000;
            dat_q   <= 8'h00;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            fe_q    <= fe_d;
            p7_q    <= p7_d;
            pd_q    <= pd_d;
            p1_q    <= p1_d;
            req_q   <= req_d;
            own_q   <= own_d;
            a_q     <= a_d;
            dat_q   <= dat_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus_req  = req_q;
    assign bus_own  = own_q;
    assign io_a     = a_q;
    assign io_d     = dat_q;
    assign io_ioreq = stb_q;
    assign io_wr    = stb_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
